ss_display_mux: RTL and testbench



---
 rtl/ss_display_mux.sv | 175 +++++++++++++++++
 tb/tb_ss_display_mux.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_display_mux.sv
// ss_display_mux: time-multiplexed seven-segment scanner with
// blanking, decimal points, PWM brightness and selectable polarity.
module ss_display_mux #(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 1000,
    parameter int PWM_BITS       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_en,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [N_DIGITS-1:0]   control_pins,
    output logic [6:0]            display_pins,
    output logic                  dp_pin,
    output logic                  frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int PB = PWM_BITS + CW + 1;

    localparam logic [CW-1:0] PRE_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic [PB-1:0] DIV_PB  = PB'(CLK_DIV);

    localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIG_ACTIVE_LOW}};

    logic [CW-1:0]           pre_cnt_q, pre_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   bcd_q;
    logic [N_DIGITS-1:0]     dp_q;
    logic                    blank_q;
    logic [PWM_BITS-1:0]     bright_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_pin_q, dp_pin_d;
    logic [N_DIGITS-1:0]     dig_q, dig_d;
    logic                    frame_q, frame_d;

    logic                    tick;
    logic                    capture;
    logic [4*N_DIGITS-1:0]   bcd_s;
    logic [N_DIGITS-1:0]     dp_s;
    logic                    blank_s;
    logic [PWM_BITS-1:0]     bright_s;

    logic [N_DIGITS-1:0]     blank_v;
    logic                    all_zero;
    logic [3:0]              code;
    logic                    dig_blank;
    logic                    dp_sel;
    logic [N_DIGITS-1:0]     sel_oh;
    logic [6:0]              seg_l;
    logic [PB-1:0]           prod;
    logic [PB-1:0]           on_time;
    logic                    dig_on;

    assign tick    = (pre_cnt_q == PRE_MAX);
    assign capture = enable && (pre_cnt_q == '0) && (idx_q == '0);

    // The first cycle of a frame already uses the inputs being latched.
    assign bcd_s    = capture ? bcd_in     : bcd_q;
    assign dp_s     = capture ? dp_in      : dp_q;
    assign blank_s  = capture ? blank_en   : blank_q;
    assign bright_s = capture ? brightness : bright_q;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        idx_d     = idx_q;
        if (!enable) begin
            pre_cnt_d = '0;
            idx_d     = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            idx_d     = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    always_comb begin
        all_zero = 1'b1;
        blank_v  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (bcd_s[4*i +: 4] == 4'd0);
            if (i > 0) begin
                blank_v[i] = blank_s && all_zero;
            end
        end
    end

    always_comb begin
        code      = '0;
        dig_blank = 1'b0;
        dp_sel    = 1'b0;
        sel_oh    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                code      = bcd_s[4*i +: 4];
                dig_blank = blank_v[i];
                dp_sel    = dp_s[i];
                sel_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_l = 7'b1000000;
        unique case (code)
            4'd0:    seg_l = 7'h3F;
            4'd1:    seg_l = 7'h06;
            4'd2:    seg_l = 7'h5B;
            4'd3:    seg_l = 7'h4F;
            4'd4:    seg_l = 7'h66;
            4'd5:    seg_l = 7'h6D;
            4'd6:    seg_l = 7'h7D;
            4'd7:    seg_l = 7'h07;
            4'd8:    seg_l = 7'h7F;
            4'd9:    seg_l = 7'h6F;
            default: seg_l = 7'b1000000;
        endcase
        if (dig_blank) begin
            seg_l = 7'h00;
        end
    end

    // Full-scale brightness keeps the digit on for the whole slot.
    assign prod    = PB'(bright_s) * DIV_PB;
    assign on_time = (&bright_s) ? DIV_PB : (prod >> PWM_BITS);
    assign dig_on  = enable && (PB'(pre_cnt_q) < on_time);

    assign seg_d    = seg_l ^ SEG_OFF;
    assign dp_pin_d = dp_sel ^ SEG_ACTIVE_LOW;
    assign dig_d    = (dig_on ? sel_oh : '0) ^ DIG_OFF;
    assign frame_d  = enable && tick && (idx_q == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            idx_q     <= '0;
            bcd_q     <= '0;
            dp_q      <= '0;
            blank_q   <= 1'b0;
            bright_q  <= '0;
            seg_q     <= SEG_OFF;
            dp_pin_q  <= SEG_ACTIVE_LOW;
            dig_q     <= DIG_OFF;
            frame_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            idx_q     <= idx_d;
            if (capture) begin
                bcd_q    <= bcd_in;
                dp_q     <= dp_in;
                blank_q  <= blank_en;
                bright_q <= brightness;
            end
            seg_q     <= seg_d;
            dp_pin_q  <= dp_pin_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
        end
    end

    assign control_pins = dig_q;
    assign display_pins = seg_q;
    assign dp_pin       = dp_pin_q;
    assign frame_done   = frame_q;

endmodule

// File: tb/tb_ss_display_mux.sv
// Bench for ss_display_mux: time-based reference model plus directed
// vectors, driving an active-high and an active-low instance together.
module tb_ss_display_mux;

    localparam int N  = 4;
    localparam int CD = 4;
    localparam int PB = 2;
    localparam int FR = N * CD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        blank;
    logic [1:0]  br;

    logic [3:0]  ctrl, ctrl_n;
    logic [6:0]  seg, seg_n;
    logic        dpo, dpo_n;
    logic        fd, fd_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ss_display_mux #(
        .N_DIGITS(N), .CLK_DIV(CD), .PWM_BITS(PB),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bcd_in(bcd), .dp_in(dp), .blank_en(blank),
        .brightness(br), .control_pins(ctrl),
        .display_pins(seg), .dp_pin(dpo), .frame_done(fd)
    );

    ss_display_mux #(
        .N_DIGITS(N), .CLK_DIV(CD), .PWM_BITS(PB),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bcd_in(bcd), .dp_in(dp), .blank_en(blank),
        .brightness(br), .control_pins(ctrl_n),
        .display_pins(seg_n), .dp_pin(dpo_n), .frame_done(fd_n)
    );

    function automatic logic [6:0] f_seg(
        input logic [15:0] b, input logic bl, input int slot
    );
        bit zero_up = 1'b1;
        logic [3:0] d;
        for (int j = slot; j < N; j++) begin
            if (b[4*j +: 4] != 4'd0) zero_up = 1'b0;
        end
        if (bl && slot > 0 && zero_up) return 7'h00;
        d = b[4*slot +: 4];
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [3:0] f_dig(input int t, input logic [1:0] b);
        int on_t;
        on_t = (b == 2'b11) ? CD : ((int'(b) * CD) >> PB);
        if ((t % CD) < on_t) return 4'(1 << ((t / CD) % N));
        return 4'b0000;
    endfunction

    // Reference: m_t is time since scanning (re)started.
    int          m_t;
    logic [15:0] s_bcd;
    logic [3:0]  s_dp;
    logic        s_bl;
    logic [1:0]  s_br;
    logic [3:0]  e_dig;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_chk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   <= 0;
            s_bcd <= '0;
            s_dp  <= '0;
            s_bl  <= 1'b0;
            s_br  <= '0;
            e_dig <= '0;
            e_seg <= '0;
            e_dp  <= 1'b0;
            e_fd  <= 1'b0;
            e_chk <= 1'b1;
        end else if (!enable) begin
            m_t   <= 0;
            e_dig <= '0;
            e_fd  <= 1'b0;
            e_chk <= 1'b0;
        end else begin
            if (m_t % FR == 0) begin
                s_bcd <= bcd;
                s_dp  <= dp;
                s_bl  <= blank;
                s_br  <= br;
            end
            e_dig <= f_dig(m_t, (m_t % FR == 0) ? br : s_br);
            e_seg <= f_seg((m_t % FR == 0) ? bcd : s_bcd,
                           (m_t % FR == 0) ? blank : s_bl,
                           (m_t / CD) % N);
            e_dp  <= (m_t % FR == 0) ? dp[(m_t / CD) % N]
                                     : s_dp[(m_t / CD) % N];
            e_fd  <= (m_t % FR == FR - 1);
            e_chk <= 1'b1;
            m_t   <= m_t + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [6:0] ns;
        logic [3:0] nd;
        logic       ndp;
        @(negedge clk);
        ns  = ~e_seg;
        nd  = ~e_dig;
        ndp = ~e_dp;
        chk("ctrl", ctrl, e_dig);
        chk("fdone", fd, e_fd);
        chk("ctrl_al", ctrl_n, nd);
        chk("fdone_al", fd_n, e_fd);
        if (e_chk) begin
            chk("seg", seg, e_seg);
            chk("dp", dpo, e_dp);
            chk("seg_al", seg_n, ns);
            chk("dp_al", dpo_n, ndp);
        end
    endtask

    int cnt, fdc;
    int pwm_br[3]  = '{1, 2, 0};
    int pwm_cnt[3] = '{4, 8, 0};

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        bcd    = '0;
        dp     = '0;
        blank  = 1'b0;
        br     = '0;
        repeat (2) step();
        chk("rst_ctrl", ctrl, 4'h0);
        chk("rst_seg", seg, 7'h00);
        chk("rst_ctrl_al", ctrl_n, 4'hF);
        chk("rst_seg_al", seg_n, 7'h7F);

        rst_n  = 1'b1;
        enable = 1'b1;
        bcd    = 16'h1234;
        br     = 2'd3;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) begin
                chk("scan_c0", ctrl, 4'b0001);
                chk("scan_s0", seg, 7'h66);
            end
            if (k == 5) begin
                chk("scan_c1", ctrl, 4'b0010);
                chk("scan_s1", seg, 7'h4F);
            end
            if (k == 9) begin
                chk("scan_c2", ctrl, 4'b0100);
                chk("scan_s2", seg, 7'h5B);
            end
            if (k == 13) begin
                chk("scan_c3", ctrl, 4'b1000);
                chk("scan_s3", seg, 7'h06);
                chk("scan_c3_al", ctrl_n, 4'b0111);
                chk("scan_s3_al", seg_n, 7'h79);
            end
            if (k == 16) chk("scan_fd", fd, 1'b1);
        end

        blank = 1'b1;
        bcd   = 16'h0050;
        dp    = 4'b0100;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) chk("blk_s0", seg, 7'h3F);
            if (k == 5) chk("blk_s1", seg, 7'h6D);
            if (k == 9) begin
                chk("blk_s2", seg, 7'h00);
                chk("blk_dp2", dpo, 1'b1);
            end
            if (k == 13) chk("blk_s3", seg, 7'h00);
        end
        bcd = 16'h0000;
        dp  = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) chk("zero_s0", seg, 7'h3F);
            if (k == 5) chk("zero_s1", seg, 7'h00);
        end

        blank = 1'b0;
        bcd   = 16'h1234;
        for (int p = 0; p < 3; p++) begin
            br  = 2'(pwm_br[p]);
            cnt = 0;
            fdc = 0;
            for (int k = 1; k <= 16; k++) begin
                step();
                if (ctrl != 4'b0) cnt++;
                if (fd) fdc++;
            end
            chk("pwm_on", cnt, pwm_cnt[p]);
            chk("pwm_fd", fdc, 1);
        end

        br  = 2'd3;
        bcd = 16'h00A0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) chk("inv_s0", seg, 7'h3F);
            if (k == 5) chk("inv_s1", seg, 7'h40);
        end

        bcd = 16'h1234;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 5) bcd = 16'h5678;
            if (k == 9) chk("snap_s2", seg, 7'h5B);
            if (k == 13) chk("snap_s3", seg, 7'h06);
        end
        step();
        chk("snap_new", seg, 7'h7F);

        repeat (8) step();
        chk("pre_rst_c2", ctrl, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", ctrl, 4'h0);
        chk("arst_seg", seg, 7'h00);
        chk("arst_ctrl_al", ctrl_n, 4'hF);
        chk("arst_seg_al", seg_n, 7'h7F);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_c0", ctrl, 4'b0001);
        chk("post_rst_s0", seg, 7'h7F);

        enable = 1'b0;
        fdc    = 0;
        repeat (10) begin
            step();
            if (fd) fdc++;
        end
        chk("dis_ctrl", ctrl, 4'h0);
        chk("dis_fd", fdc, 0);
        enable = 1'b1;
        step();
        chk("reen_c0", ctrl, 4'b0001);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
